// File: rtl/branch_predictor_table_if.sv
// Lookup and training signals for the branch predictor.
// The IF/EX pipeline side is the master and the predictor is the slave.
interface branch_predictor_table_if #(
    parameter int GHR_BITS = 5
) ();
    logic [31:0]         pc;
    logic                pred_taken;
    logic [31:0]         pred_next_pc;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                update_valid;
    logic [31:0]         update_pc;
    logic [GHR_BITS-1:0] update_ghr;
    logic                update_taken;
    logic [31:0]         update_target;

    modport master (
        output pc, update_valid, update_pc, update_ghr, update_taken, update_target,
        input  pred_taken, pred_next_pc, pred_ghr
    );

    modport slave (
        input  pc, update_valid, update_pc, update_ghr, update_taken, update_target,
        output pred_taken, pred_next_pc, pred_ghr
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Saturating-counter branch predictor (bimodal or gshare) with a tagged BTB.
// Lookup is combinational from pc; training happens on the clock edge.
module branch_predictor_table #(
    parameter int CNT_BITS = 2,
    parameter int IDX_BITS = 5,
    parameter int GHR_BITS = 5,
    parameter int GSHARE   = 1
) (
    input logic clk,
    input logic reset,
    branch_predictor_table_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1 << (CNT_BITS - 1));

    logic [GHR_BITS-1:0] ghr_reg;
    logic [GHR_BITS-1:0] ghr_next;
    logic [CNT_BITS-1:0] cnt_arr [ENTRIES];
    logic [ENTRIES-1:0]  btb_valid;
    logic [TAG_W-1:0]    btb_tag_mem    [ENTRIES];
    logic [31:0]         btb_target_mem [ENTRIES];

    // Counter index: gshare folds the zero-extended history into the PC bits.
    function automatic logic [IDX_BITS-1:0] counter_index(
        input logic [IDX_BITS-1:0] base,
        input logic [GHR_BITS-1:0] hist
    );
        if (GSHARE != 0) begin
            return base ^ IDX_BITS'(hist);
        end
        return base;
    endfunction

    // Lookup side
    logic [IDX_BITS-1:0] look_bi;
    logic [IDX_BITS-1:0] look_ci;
    logic                look_hit;

    assign look_bi  = bp.pc[IDX_BITS+1:2];
    assign look_ci  = counter_index(look_bi, ghr_reg);
    assign look_hit = btb_valid[look_bi] && (btb_tag_mem[look_bi] == bp.pc[31:IDX_BITS+2]);

    assign bp.pred_taken   = look_hit && cnt_arr[look_ci][CNT_BITS-1];
    assign bp.pred_next_pc = bp.pred_taken ? btb_target_mem[look_bi] : bp.pc + 32'd4;
    assign bp.pred_ghr     = ghr_reg;

    // Update side: the counter index uses the history snapshot carried with the branch
    logic [IDX_BITS-1:0] upd_bi;
    logic [IDX_BITS-1:0] upd_ci;
    logic [CNT_BITS-1:0] upd_cnt_cur;
    logic [CNT_BITS-1:0] upd_cnt_next;

    assign upd_bi      = bp.update_pc[IDX_BITS+1:2];
    assign upd_ci      = counter_index(upd_bi, bp.update_ghr);
    assign upd_cnt_cur = cnt_arr[upd_ci];

    always_comb begin
        upd_cnt_next = upd_cnt_cur;
        if (bp.update_taken) begin
            if (upd_cnt_cur != CNT_MAX) begin
                upd_cnt_next = upd_cnt_cur + 1'b1;
            end
        end else begin
            if (upd_cnt_cur != '0) begin
                upd_cnt_next = upd_cnt_cur - 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic [CNT_BITS-1:0] cnt_reg;
        logic                valid_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg   <= CNT_INIT;
                valid_reg <= 1'b0;
            end else if (bp.update_valid) begin
                if (upd_ci == IDX_BITS'(gi)) begin
                    cnt_reg <= upd_cnt_next;
                end
                if (bp.update_taken && (upd_bi == IDX_BITS'(gi))) begin
                    valid_reg <= 1'b1;
                end
            end
        end

        assign cnt_arr[gi]   = cnt_reg;
        assign btb_valid[gi] = valid_reg;
    end

    // Tags and targets need no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (bp.update_valid && bp.update_taken) begin
            btb_tag_mem[upd_bi]    <= bp.update_pc[31:IDX_BITS+2];
            btb_target_mem[upd_bi] <= bp.update_target;
        end
    end

    // Shift the outcome in; truncation keeps the newest GHR_BITS bits (also covers GHR_BITS=1).
    assign ghr_next = GHR_BITS'({ghr_reg, bp.update_taken});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_reg <= '0;
        end else if (bp.update_valid) begin
            ghr_reg <= ghr_next;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc[1:0], bp.update_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench: a bimodal and a gshare instance share stimulus and are
// checked each cycle against an array-based reference model.
module tb_branch_predictor_table;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_table_if #(.GHR_BITS(5)) bif_b ();
    branch_predictor_table_if #(.GHR_BITS(5)) bif_g ();

    branch_predictor_table #(.CNT_BITS(2), .IDX_BITS(5), .GHR_BITS(5), .GSHARE(0)) u_bim (
        .clk(clk), .reset(rst_n), .bp(bif_b)
    );
    branch_predictor_table #(.CNT_BITS(2), .IDX_BITS(5), .GHR_BITS(5), .GSHARE(1)) u_gsh (
        .clk(clk), .reset(rst_n), .bp(bif_g)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken [2];
        logic [31:0] next  [2];
        logic [4:0]  ghr   [2];
    } exp_t;

    exp_t exp_q [$];
    int checks = 0;
    int errors = 0;
    int txn = 0;

    // Reference model: index 0 = bimodal, 1 = gshare; 2-bit counters, 32 entries
    int          m_cnt [2][32];
    bit          m_val [2][32];
    int unsigned m_tag [2][32];
    logic [31:0] m_tgt [2][32];
    int          m_ghr [2];

    function automatic int base_idx(logic [31:0] p);
        return int'((p >> 2) % 32);
    endfunction

    function automatic int cnt_idx(int k, logic [31:0] p, int g);
        return (k == 1) ? (base_idx(p) ^ g) : base_idx(p);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ghr[k] = 0;
            for (int i = 0; i < 32; i++) begin
                m_cnt[k][i] = 2;
                m_val[k][i] = 1'b0;
            end
        end
    endtask

    task automatic model_update(int k, logic [31:0] upc, int ughr, logic t, logic [31:0] tgt);
        int ci;
        int bi;
        ci = cnt_idx(k, upc, ughr);
        bi = base_idx(upc);
        if (t) m_cnt[k][ci] = (m_cnt[k][ci] + 1 > 3) ? 3 : m_cnt[k][ci] + 1;
        else   m_cnt[k][ci] = (m_cnt[k][ci] - 1 < 0) ? 0 : m_cnt[k][ci] - 1;
        if (t) begin
            m_val[k][bi] = 1'b1;
            m_tag[k][bi] = upc >> 7;
            m_tgt[k][bi] = tgt;
        end
        m_ghr[k] = ((m_ghr[k] * 2) + (t ? 1 : 0)) % 32;
    endtask

    // ughr_sel < 0: each branch carries its predictor's live history; otherwise that value
    task automatic drive(input logic rst_in, input logic [31:0] p, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input int ughr_sel);
        exp_t e;
        int   ug [2];
        @(posedge clk);
        #1;
        rst_n = rst_in;
        if (!rst_in) model_reset();
        for (int k = 0; k < 2; k++) ug[k] = (ughr_sel < 0) ? m_ghr[k] : ughr_sel;
        bif_b.pc = p;            bif_g.pc = p;
        bif_b.update_valid = uv; bif_g.update_valid = uv;
        bif_b.update_pc = upc;   bif_g.update_pc = upc;
        bif_b.update_taken = ut; bif_g.update_taken = ut;
        bif_b.update_target = utgt; bif_g.update_target = utgt;
        bif_b.update_ghr = 5'(ug[0]);
        bif_g.update_ghr = 5'(ug[1]);
        e.pc = p;
        for (int k = 0; k < 2; k++) begin
            int  bi;
            bit  hit;
            bi  = base_idx(p);
            hit = m_val[k][bi] && (m_tag[k][bi] == (p >> 7));
            e.taken[k] = hit && (m_cnt[k][cnt_idx(k, p, m_ghr[k])] >= 2);
            e.next[k]  = e.taken[k] ? m_tgt[k][bi] : p + 32'd4;
            e.ghr[k]   = 5'(m_ghr[k]);
        end
        exp_q.push_back(e);
        if (rst_in && uv) begin
            for (int k = 0; k < 2; k++) model_update(k, upc, ug[k], ut, utgt);
        end
    endtask

    task automatic look(input logic [31:0] p);
        drive(1'b1, p, 1'b0, 32'h0, 1'b0, 32'h0, -1);
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt);
        drive(1'b1, p, 1'b1, upc, ut, utgt, -1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents one lookup result
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("bim_taken", 32'(bif_b.pred_taken), 32'(e.taken[0]));
            chk("bim_next",  bif_b.pred_next_pc,    e.next[0]);
            chk("bim_ghr",   32'(bif_b.pred_ghr),   32'(e.ghr[0]));
            chk("gsh_taken", 32'(bif_g.pred_taken), 32'(e.taken[1]));
            chk("gsh_next",  bif_g.pred_next_pc,    e.next[1]);
            chk("gsh_ghr",   32'(bif_g.pred_ghr),   32'(e.ghr[1]));
            $display("txn %0d pc=%h bim=%0b/%h gsh=%0b/%h ghr=%0d", txn, e.pc,
                     bif_b.pred_taken, bif_b.pred_next_pc,
                     bif_g.pred_taken, bif_g.pred_next_pc, bif_g.pred_ghr);
            txn++;
        end
    end

    logic [31:0] pcs [6];

    initial begin
        pcs[0] = 32'h100; pcs[1] = 32'h180; pcs[2] = 32'h104;
        pcs[3] = 32'h118; pcs[4] = 32'hFFFF_FFFC; pcs[5] = 32'h200;
        bif_b.pc = '0; bif_b.update_valid = 1'b0; bif_b.update_pc = '0;
        bif_b.update_ghr = '0; bif_b.update_taken = 1'b0; bif_b.update_target = '0;
        bif_g.pc = '0; bif_g.update_valid = 1'b0; bif_g.update_pc = '0;
        bif_g.update_ghr = '0; bif_g.update_taken = 1'b0; bif_g.update_target = '0;
        model_reset();

        // Reset state, then release
        drive(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, -1);
        look(32'h100);
        // One taken, then two not-taken
        upd(32'h100, 32'h100, 1'b1, 32'h80);
        look(32'h100);
        upd(32'h100, 32'h100, 1'b0, 32'h0);
        look(32'h100);
        upd(32'h100, 32'h100, 1'b0, 32'h0);
        look(32'h100);
        // Saturation both ways, then one taken
        repeat (5) upd(32'h100, 32'h100, 1'b1, 32'h80);
        look(32'h100);
        repeat (5) upd(32'h100, 32'h100, 1'b0, 32'h80);
        look(32'h100);
        upd(32'h100, 32'h100, 1'b1, 32'h80);
        look(32'h100);
        // BTB aliasing
        upd(32'h100, 32'h100, 1'b1, 32'h80);
        look(32'h180);
        upd(32'h180, 32'h180, 1'b1, 32'h40);
        look(32'h100);
        look(32'h180);
        // Reset mid-run with an update pending: outputs drop without an edge, update lost
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, -1);
        look(32'h100);
        // History: T, T, NT then lookup and a trained update using the snapshot
        upd(32'h100, 32'h100, 1'b1, 32'h80);
        upd(32'h100, 32'h100, 1'b1, 32'h80);
        upd(32'h100, 32'h100, 1'b0, 32'h80);
        look(32'h100);
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 6);
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 6);
        look(32'h100);
        // Same-cycle collision: lookup sees the old state
        drive(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, -1);
        upd(32'h100, 32'h100, 1'b1, 32'h80);
        upd(32'h100, 32'h100, 1'b0, 32'h80);
        upd(32'h100, 32'h100, 1'b1, 32'h80);
        look(32'h100);
        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] p;
            logic [31:0] up;
            p  = pcs[$urandom_range(0, 5)];
            up = pcs[$urandom_range(0, 5)];
            drive(($urandom_range(0, 49) != 0), p, 1'($urandom_range(0, 1)), up,
                  1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
